// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard I/O responder.
package ps2_kbd_pkg;

  localparam int unsigned ADDR_DATA    = 0;
  localparam int unsigned ADDR_STATUS  = 4;
  localparam int unsigned ADDR_SEL_BIT = 2;

  localparam int unsigned BIT_READY = 31;
  localparam int unsigned BIT_OVF   = 30;
  localparam int unsigned BIT_FERR  = 29;
  localparam int unsigned CNT_LSB   = 8;

  localparam int unsigned CTL_FLUSH     = 0;
  localparam int unsigned CTL_CLR_FLAGS = 1;

  localparam int unsigned FRAME_BITS = 11;

  typedef enum logic {StIdle, StRecv} rx_state_e;

  // Frame is {stop, parity, data[7:0], start}; odd parity over data+parity.
  function automatic logic frame_ok(input logic [10:0] f);
    return !f[0] && f[10] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_kbd_io_if.sv
// CPU I/O bus signals seen by the keyboard responder.
interface ps2_kbd_io_if;
  logic        io_rdn;
  logic        io_wrn;
  logic [31:0] m_addr;
  logic [31:0] d_t_mem;
  logic [31:0] d_io;
  logic        irq;

  modport master (output io_rdn, output io_wrn, output m_addr, output d_t_mem,
                  input d_io, input irq);
  modport slave  (input io_rdn, input io_wrn, input m_addr, input d_t_mem,
                  output d_io, output irq);
endinterface

// File: rtl/kbd_fifo.sv
// Byte FIFO with show-ahead output; push at full is accepted when a pop coincides.
module kbd_fifo #(
  parameter int unsigned AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_flush,
  input  logic [7:0]  i_din,
  output logic [7:0]  o_dout,
  output logic [AW:0] o_count,
  output logic        o_full,
  output logic        o_empty
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/ps2_kbd_io.sv
// PS/2 keyboard receiver with scan-code FIFO, served over the CPU I/O bus.
module ps2_kbd_io
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned TIMEOUT     = 5000
) (
  input logic         clk,
  input logic         clr,
  input logic         ps2_clk,
  input logic         ps2_data,
  ps2_kbd_io_if.slave bus
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  rx_state_e              r_state, w_state_nx;
  logic [3:0]             r_bitcnt, w_bitcnt_nx;
  logic [10:0]            r_shift, w_shift_nx;
  logic [TW-1:0]          r_tmo, w_tmo_nx;
  logic                   r_push, w_push_nx;
  logic [7:0]             r_byte;
  logic                   r_ovf, r_ferr;
  logic                   w_ferr_set, w_edge, w_bit;
  logic [10:0]            w_frame;
  logic                   w_rd, w_wr, w_sel_status, w_pop, w_flush, w_clr_flags, w_ovf_set;
  logic [7:0]             w_head;
  logic [FIFO_AW:0]       w_count;
  logic                   w_full, w_empty;
  logic [31:0]            w_rdata;
  logic                   w_unused_bits;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge  = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_bit   = r_dat_sync[SYNC_STAGES-1];
  assign w_frame = {w_bit, r_shift[10:1]};

  always_comb begin
    w_state_nx  = r_state;
    w_bitcnt_nx = r_bitcnt;
    w_shift_nx  = r_shift;
    w_tmo_nx    = '0;
    w_push_nx   = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_edge && !w_bit) begin
          w_state_nx  = StRecv;
          w_bitcnt_nx = 4'd1;
          w_shift_nx  = w_frame;
        end
      end
      StRecv: begin
        if (w_edge) begin
          w_shift_nx = w_frame;
          if (r_bitcnt == 4'(FRAME_BITS - 1)) begin
            w_state_nx  = StIdle;
            w_bitcnt_nx = '0;
            w_push_nx   = frame_ok(w_frame);
            w_ferr_set  = ~frame_ok(w_frame);
          end else begin
            w_bitcnt_nx = r_bitcnt + 4'd1;
          end
        end else if (r_tmo == TMO_LIMIT) begin
          // Stalled partial frame: abandon it silently.
          w_state_nx  = StIdle;
          w_bitcnt_nx = '0;
        end else begin
          w_tmo_nx = r_tmo + 1'b1;
        end
      end
      default: w_state_nx = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= StIdle;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tmo    <= '0;
      r_push   <= 1'b0;
      r_byte   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_shift  <= w_shift_nx;
      r_tmo    <= w_tmo_nx;
      r_push   <= w_push_nx;
      if (w_push_nx) r_byte <= w_frame[8:1];
    end
  end

  // A write alongside a read suppresses the pop; the read still sees the pre-write word.
  assign w_rd         = ~bus.io_rdn;
  assign w_wr         = ~bus.io_wrn;
  assign w_sel_status = bus.m_addr[ADDR_SEL_BIT];
  assign w_pop        = w_rd & ~w_wr & ~w_sel_status;
  assign w_flush      = w_wr & w_sel_status & bus.d_t_mem[CTL_FLUSH];
  assign w_clr_flags  = w_wr & w_sel_status & bus.d_t_mem[CTL_CLR_FLAGS];
  assign w_ovf_set    = r_push & w_full & ~w_pop & ~w_flush;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovf  <= w_ovf_set | (r_ovf & ~w_clr_flags);
      r_ferr <= w_ferr_set | (r_ferr & ~w_clr_flags);
    end
  end

  kbd_fifo #(
    .AW(FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (clr),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (r_byte),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_rdata                          = '0;
    w_rdata[BIT_READY]               = ~w_empty;
    w_rdata[BIT_OVF]                 = r_ovf;
    w_rdata[BIT_FERR]                = r_ferr;
    w_rdata[CNT_LSB +: FIFO_AW + 1]  = w_count;
    w_rdata[7:0]                     = w_empty ? 8'h00 : w_head;
  end

  assign bus.d_io = w_rdata;
  assign bus.irq  = ~w_empty;

  assign w_unused_bits = ^{bus.m_addr[31:3], bus.m_addr[1:0], bus.d_t_mem[31:2]};

endmodule
